aes_inv_key_expansion: RTL and testbench
========================================

AES_INV_KEY_EXPANSION -- requirements
Module: aes_inv_key_expansion

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The module SHALL provide these ports, one per line as name, direction, width, meaning:
- clk_i  input  1  clock; all state on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- clk_en_i  input  1  clock enable; when 0, all state holds.
- start_i  input  1  start request; accepted only in IDLE.
- last_key_i  input  128  round-10 key, sampled on accepted start; word 0 = [127:96].
- key_ready_i  input  1  consumer ready for key_o.
- key_o  output  128  current round key.
- round_o  output  4  round index of key_o, 10 down to 0.
- key_valid_o  output  1  key_o and round_o valid.
- busy_o  output  1  high from accepted start until return to IDLE.
- done_o  output  1  one-cycle pulse after the round-0 key is consumed.

Function
REQ-003 The module SHALL implement states IDLE and RUN.
REQ-004 In IDLE with clk_en_i=1 and start_i=1, the module SHALL:
- load last_key_i into key_o;
- set round_o to 10;
- move to RUN;
- key_valid_o=1 and busy_o=1 from the next cycle.
REQ-005 A start_i while in RUN SHALL be ignored, including in the cycle of the final handshake.
REQ-006 A handshake SHALL occur only on a cycle with key_valid_o=1, key_ready_i=1 and clk_en_i=1.
REQ-007 While key_valid_o=1 and no handshake occurs, key_o and round_o SHALL hold stable.
REQ-008 On a handshake with round_o>0, the module SHALL:
- replace key_o with the previous round key (REQ-009);
- decrement round_o;
- stay in RUN with key_valid_o=1.
REQ-009 The previous-key step SHALL work on current words w0..w3 (w0=[127:96]):
- p3=w3^w2; p2=w2^w1; p1=w1^w0;
- p0=w0^SubWord(RotWord(p3))^{rcon,24'h0};
- RotWord is a left byte rotation; SubWord uses the forward AES S-box.
REQ-010 rcon SHALL be indexed by the current round_o, with 10..1 mapping to 36,1b,80,40,20,10,08,04,02,01 (hex).
REQ-011 On a handshake with round_o=0, the module SHALL:
- return to IDLE;
- drop key_valid_o and busy_o in the next cycle;
- pulse done_o for exactly that one cycle;
- retain key_o and round_o.
REQ-012 With key_ready_i held at 1 and clk_en_i=1, the module SHALL:
- present 11 keys on 11 consecutive cycles starting 1 cycle after start;
- assert done_o 12 cycles after the start cycle.
REQ-013 When clk_en_i=0, the module SHALL:
- freeze state, key, round and busy_o;
- hold done_o at 0;
- ignore key_ready_i and start_i.
REQ-014 The key update SHALL be a single registered step per handshake, with no multi-cycle S-box pipeline.

Reset
REQ-015 When rst_i=0, the module SHALL immediately, without a clock edge, set:
- state=IDLE;
- key_o=0 and round_o=0;
- key_valid_o=0, busy_o=0, done_o=0.
REQ-016 A reset asserted mid-run SHALL abandon the sequence, and no done_o SHALL follow it.
REQ-017 After rst_i deasserts, the first accepted start_i SHALL behave exactly as in REQ-004.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- FIPS-197 vector, ready=1: last_key_i=d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 9 = ac7766f319fadc2128d12941575c006e, 1 = a0fafe1788542cb123a339392a6c7605, 0 = 2b7e151628aed2a6abf7158809cf4f3c; done_o 12 cycles after start.
- Backpressure: key_ready_i pseudo-random -> same 11-key sequence; key_o/round_o stable whenever valid&&!ready.
- Start during RUN (round_o=6) with last_key_i=0 -> ignored; sequence and done_o timing unchanged.
- clk_en_i=0 for 5 cycles at round_o=4 -> no output change; completion delayed exactly 5 cycles.
- rst_i low at round_o=5 -> outputs zero with no clock edge; a new start then reproduces the FIPS-197 sequence.
- Round trip: random key into aes_key_expansion, its round_keys[10] into this block -> outputs equal round_keys[10] down to [0].

Source files
------------

// File: rtl/aes_inv_key_expansion.sv
// AES-128 inverse key schedule: walks round keys 10 down to 0,
// one registered step per valid/ready handshake.
module aes_inv_key_expansion (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic         start_i,
  input  logic [127:0] last_key_i,
  input  logic         key_ready_i,
  output logic [127:0] key_o,
  output logic [3:0]   round_o,
  output logic         key_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]],
                SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    rcon = 8'h00;
    unique case (r)
      4'd10:   rcon = 8'h36;
      4'd9:    rcon = 8'h1b;
      4'd8:    rcon = 8'h80;
      4'd7:    rcon = 8'h40;
      4'd6:    rcon = 8'h20;
      4'd5:    rcon = 8'h10;
      4'd4:    rcon = 8'h08;
      4'd3:    rcon = 8'h04;
      4'd2:    rcon = 8'h02;
      4'd1:    rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       state_q;
  state_t       state_d;
  logic [127:0] key_d;
  logic [3:0]   round_d;
  logic         done_q;
  logic         done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3;
  logic [127:0] prev_key;

  assign w0 = key_o[127:96];
  assign w1 = key_o[95:64];
  assign w2 = key_o[63:32];
  assign w3 = key_o[31:0];

  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign rot_p3 = {p3[23:0], p3[31:24]};
  assign p0     = w0 ^ sub_word(rot_p3)
                ^ {rcon(round_o), 24'h0};

  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_o;
    round_d = round_o;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          key_d   = last_key_i;
          round_d = 4'd10;
        end
      end
      RUN: begin
        if (key_ready_i) begin
          if (round_o == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_o - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A gated-off cycle freezes everything, including a pending done pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      key_o   <= '0;
      round_o <= '0;
      done_q  <= 1'b0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      key_o   <= key_d;
      round_o <= round_d;
      done_q  <= done_d;
    end
  end

  assign key_valid_o = (state_q == RUN);
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q & clk_en_i;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Bench for aes_inv_key_expansion: forward-expansion model with
// a computed S-box feeds a scoreboard of expected round keys.
module tb_aes_inv_key_expansion;

  logic         clk;
  logic         rst_i;
  logic         clk_en_i;
  logic         start_i;
  logic [127:0] last_key_i;
  logic         key_ready_i;
  logic [127:0] key_o;
  logic [3:0]   round_o;
  logic         key_valid_o;
  logic         busy_o;
  logic         done_o;

  aes_inv_key_expansion dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .start_i     (start_i),
    .last_key_i  (last_key_i),
    .key_ready_i (key_ready_i),
    .key_o       (key_o),
    .round_o     (round_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } vec_t;

  exp_t         sb[$];
  logic [7:0]   sbox_t[256];
  logic [127:0] rk[11];
  logic [127:0] cap[11];
  vec_t         fips[4];
  int           n_chk;
  int           n_fail;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    logic [7:0] y;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (x != 0 && gmul(x, y) == 8'h01) inv = y;
      end
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
             sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: ready=1, 1: random ready, 2: start in RUN, 3: 5-cycle stall
  task automatic run_seq(input logic [127:0] k0,
                         input int mode,
                         output int done_cyc);
    exp_t         e;
    int           freeze;
    bit           seen4;
    bit           pv;
    bit           phs;
    bit           hs;
    logic [127:0] pk;
    logic [3:0]   pr;
    expand(k0);
    sb.delete();
    for (int r = 10; r >= 0; r--) begin
      e.key = rk[r];
      e.rnd = 4'(r);
      sb.push_back(e);
    end
    done_cyc = -1;
    freeze   = 0;
    seen4    = 0;
    pv       = 0;
    phs      = 0;
    pk       = '0;
    pr       = '0;
    @(negedge clk);
    start_i     = 1'b1;
    last_key_i  = rk[10];
    key_ready_i = 1'b1;
    clk_en_i    = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start_i    = 1'b0;
      last_key_i = '0;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (key_valid_o && pv && !phs) begin
        chk("hold_key", key_o, pk);
        chk("hold_round", 128'(round_o), 128'(pr));
      end
      pv = key_valid_o;
      pk = key_o;
      pr = round_o;
      key_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      clk_en_i    = 1'b1;
      if (mode == 2 && key_valid_o &&
          (round_o == 4'd6 || round_o == 4'd0)) begin
        start_i    = 1'b1;
        last_key_i = '0;
      end
      if (mode == 3 && key_valid_o && round_o == 4'd4 && !seen4) begin
        seen4  = 1;
        freeze = 5;
      end
      if (freeze > 0) begin
        clk_en_i    = 1'b0;
        key_ready_i = 1'b1;
        start_i     = 1'b1;
        freeze--;
      end
      hs = key_valid_o && key_ready_i && clk_en_i;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("sb_extra_key", 128'(round_o), 128'hf);
        end else begin
          e = sb.pop_front();
          chk("key_seq", key_o, e.key);
          chk("round_seq", 128'(round_o), 128'(e.rnd));
          cap[round_o] = key_o;
        end
      end
      phs = hs;
    end
    start_i     = 1'b0;
    key_ready_i = 1'b0;
    clk_en_i    = 1'b1;
    if (done_cyc < 0) begin
      chk("done_timeout", 128'(done_cyc), 128'd0);
    end else begin
      chk("sb_empty", 128'(sb.size()), 128'd0);
      chk("idle_valid", 128'(key_valid_o), 128'd0);
      chk("idle_busy", 128'(busy_o), 128'd0);
      chk("keep_key", key_o, rk[0]);
      chk("keep_round", 128'(round_o), 128'd0);
      @(negedge clk);
      chk("done_one_cycle", 128'(done_o), 128'd0);
    end
  endtask

  initial begin
    int  dc;
    bit  seen_done;
    n_chk  = 0;
    n_fail = 0;
    fips[0].rnd = 4'd10;
    fips[0].key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips[1].rnd = 4'd9;
    fips[1].key = 128'hac7766f319fadc2128d12941575c006e;
    fips[2].rnd = 4'd1;
    fips[2].key = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[3].rnd = 4'd0;
    fips[3].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    rst_i       = 1'b0;
    clk_en_i    = 1'b1;
    start_i     = 1'b0;
    last_key_i  = '0;
    key_ready_i = 1'b0;
    build_sbox();
    #3;
    chk("rst_key", key_o, 128'd0);
    chk("rst_round", 128'(round_o), 128'd0);
    chk("rst_valid", 128'(key_valid_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    @(negedge clk);
    rst_i = 1'b1;

    run_seq(fips[3].key, 0, dc);
    chk("fips_done_lat", 128'(dc), 128'd12);
    for (int i = 0; i < 4; i++)
      chk("fips_vec", cap[fips[i].rnd], fips[i].key);

    run_seq(fips[3].key, 1, dc);
    for (int i = 0; i < 4; i++)
      chk("bp_vec", cap[fips[i].rnd], fips[i].key);

    run_seq(fips[3].key, 2, dc);
    chk("start_in_run_lat", 128'(dc), 128'd12);

    run_seq(fips[3].key, 3, dc);
    chk("stall_lat", 128'(dc), 128'd17);

    // abandon a run at round 5 with an edge-free reset
    @(negedge clk);
    start_i     = 1'b1;
    last_key_i  = fips[0].key;
    key_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (round_o == 4'd5 && key_valid_o) break;
    end
    chk("pre_rst_round", 128'(round_o), 128'd5);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_key", key_o, 128'd0);
    chk("async_rst_round", 128'(round_o), 128'd0);
    chk("async_rst_valid", 128'(key_valid_o), 128'd0);
    chk("async_rst_busy", 128'(busy_o), 128'd0);
    @(negedge clk);
    rst_i     = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_o || key_valid_o) seen_done = 1;
    end
    chk("no_done_after_rst", 128'(seen_done), 128'd0);
    run_seq(fips[3].key, 0, dc);
    chk("post_rst_lat", 128'(dc), 128'd12);
    for (int i = 0; i < 4; i++)
      chk("post_rst_vec", cap[fips[i].rnd], fips[i].key);

    for (int t = 0; t < 3; t++) begin
      run_seq({$urandom, $urandom, $urandom, $urandom}, t % 2, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
